pixel_coord_scanner: RTL and testbench

Parametrised successor to the OLED pixel-index-to-coordinate converter. Tracks the display driver's pixel_index incrementally with counters instead of a per-cycle divide/modulo. On a non-sequential index jump it resynchronises with a multi-cycle iterative divider. Adds horizontal mirroring and wrap-around x/y scroll offsets, and sits between the OLED driver and all sprite/tile renderers.

---
 rtl/pixel_coord_scanner.sv | 133 +++++++++++++
 tb/tb_pixel_coord_scanner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_coord_scanner.sv
// Converts the OLED driver's linear pixel index into (x, y) coordinates.
// Sequential indices are tracked with counters. A jump to a new index is
// resolved with a one-subtract-per-cycle divider. The result is then mirrored
// and scrolled with wrap-around in a registered output stage.
module pixel_coord_scanner #(
    parameter int WIDTH  = 96,
    parameter int HEIGHT = 64,
    parameter int IDX_W  = 13,
    parameter int CW     = 7
) (
    input  logic             my_clock,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] pixel_index,
    input  logic [CW-1:0]    offset_x,
    input  logic [CW-1:0]    offset_y,
    input  logic             mirror_x,
    output logic [CW-1:0]    x,
    output logic [CW-1:0]    y,
    output logic             coord_valid,
    output logic             resync_busy
);

    localparam logic [0:0] TRACK  = 1'b0;
    localparam logic [0:0] RESYNC = 1'b1;

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH * HEIGHT - 1);
    localparam logic [IDX_W-1:0] W_IDX = IDX_W'(WIDTH);
    localparam logic [CW-1:0]    W_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    H_MAX = CW'(HEIGHT - 1);
    localparam logic [CW:0]      W_EXT = (CW + 1)'(WIDTH);
    localparam logic [CW:0]      H_EXT = (CW + 1)'(HEIGHT);

    logic [0:0]       state;
    logic [CW-1:0]    raw_x;
    logic [CW-1:0]    raw_y;
    logic [IDX_W-1:0] idx_q;
    logic             valid_raw;
    logic [IDX_W-1:0] target;
    logic [IDX_W-1:0] rem;
    logic [CW-1:0]    quo;

    logic [CW-1:0] ox_sat;
    logic [CW-1:0] oy_sat;
    logic [CW-1:0] mx;
    logic [CW:0]   sum_x;
    logic [CW:0]   sum_y;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;

    assign resync_busy = (state == RESYNC);

    // Index tracker: step the counters on +1, otherwise divide by repeated subtraction.
    always_ff @(posedge my_clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TRACK;
            raw_x     <= '0;
            raw_y     <= '0;
            idx_q     <= '0;
            valid_raw <= 1'b0;
            target    <= '0;
            rem       <= '0;
            quo       <= '0;
        end else begin
            case (state)
                TRACK: begin
                    if (pixel_index > LAST) begin
                        valid_raw <= 1'b0;
                    end else if (pixel_index == idx_q) begin
                        valid_raw <= 1'b1;
                    end else if (pixel_index == '0) begin
                        raw_x     <= '0;
                        raw_y     <= '0;
                        idx_q     <= '0;
                        valid_raw <= 1'b1;
                    end else if (pixel_index == idx_q + IDX_W'(1)) begin
                        if (raw_x == W_MAX) begin
                            raw_x <= '0;
                            raw_y <= raw_y + CW'(1);
                        end else begin
                            raw_x <= raw_x + CW'(1);
                        end
                        idx_q     <= pixel_index;
                        valid_raw <= 1'b1;
                    end else begin
                        target    <= pixel_index;
                        rem       <= pixel_index;
                        quo       <= '0;
                        valid_raw <= 1'b0;
                        state     <= RESYNC;
                    end
                end
                RESYNC: begin
                    if (rem >= W_IDX) begin
                        rem <= rem - W_IDX;
                        quo <= quo + CW'(1);
                    end else begin
                        raw_x     <= CW'(rem);
                        raw_y     <= quo;
                        idx_q     <= target;
                        valid_raw <= 1'b1;
                        state     <= TRACK;
                    end
                end
                default: state <= TRACK;
            endcase
        end
    end

    // Mirror and scroll. An out-of-range offset clamps to the last column or row.
    assign ox_sat = ({1'b0, offset_x} >= W_EXT) ? W_MAX : offset_x;
    assign oy_sat = ({1'b0, offset_y} >= H_EXT) ? H_MAX : offset_y;
    assign mx     = mirror_x ? (W_MAX - raw_x) : raw_x;
    assign sum_x  = {1'b0, mx} + {1'b0, ox_sat};
    assign sum_y  = {1'b0, raw_y} + {1'b0, oy_sat};
    assign x_next = (sum_x >= W_EXT) ? CW'(sum_x - W_EXT) : CW'(sum_x);
    assign y_next = (sum_y >= H_EXT) ? CW'(sum_y - H_EXT) : CW'(sum_y);

    // Output register. x and y keep their last values while the coordinate is invalid.
    always_ff @(posedge my_clock or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            coord_valid <= 1'b0;
        end else begin
            coord_valid <= valid_raw;
            if (valid_raw) begin
                x <= x_next;
                y <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_pixel_coord_scanner.sv
// Self-checking bench for pixel_coord_scanner (96x64 display).
// The reference model derives coordinates with div/mod and counts resync cycles.
module tb_pixel_coord_scanner;

    localparam int W    = 96;
    localparam int H    = 64;
    localparam int IW   = 13;
    localparam int CW   = 7;
    localparam int LAST = W * H - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] pi = '0;
    logic [CW-1:0] ox = '0;
    logic [CW-1:0] oy = '0;
    logic          mx = 1'b0;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          cv;
    logic          busy;

    pixel_coord_scanner #(.WIDTH(W), .HEIGHT(H), .IDX_W(IW), .CW(CW)) dut (
        .my_clock    (clk),
        .rst_n       (rst_n),
        .pixel_index (pi),
        .offset_x    (ox),
        .offset_y    (oy),
        .mirror_x    (mx),
        .x           (x),
        .y           (y),
        .coord_valid (cv),
        .resync_busy (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    int m_idx, m_target, m_busy, m_x, m_y;
    bit m_vraw, m_cv;

    typedef struct {
        int pi;
        int ox;
        int oy;
        int m;
        int ex;
        int ey;
        int ecv;
    } vec_t;

    vec_t tbl[13];

    function automatic int sat(int v, int lim);
        return (v >= lim) ? lim - 1 : v;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_target = 0; m_busy = 0;
        m_x = 0; m_y = 0; m_vraw = 0; m_cv = 0;
    endtask

    task automatic model_edge();
        int c, r, mxx, p;
        if (m_vraw) begin
            c   = m_idx % W;
            r   = m_idx / W;
            mxx = mx ? (W - 1 - c) : c;
            m_x = (mxx + sat(int'(ox), W)) % W;
            m_y = (r + sat(int'(oy), H)) % H;
        end
        m_cv = m_vraw;
        p = int'(pi);
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_idx  = m_target;
                m_vraw = 1;
            end
        end else if (p > LAST) begin
            m_vraw = 0;
        end else if (p == m_idx) begin
            m_vraw = 1;
        end else if (p == 0 || p == m_idx + 1) begin
            m_idx  = p;
            m_vraw = 1;
        end else begin
            m_target = p;
            m_busy   = p / W + 1;
            m_vraw   = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("x", int'(x), m_x);
        check("y", int'(y), m_y);
        check("coord_valid", int'(cv), int'(m_cv));
        check("resync_busy", int'(busy), (m_busy > 0) ? 1 : 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_cv", int'(cv), 0);
        check("rst_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
    endtask

    task automatic drain_busy(string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, int'(busy), 0);
    endtask

    initial begin
        int cnt, cv_bad, saw_busy, cv_drop, prev, r;

        tbl[0]  = '{0,    0,   0,   0, 0,  0,  1};
        tbl[1]  = '{1,    0,   0,   0, 1,  0,  1};
        tbl[2]  = '{95,   0,   0,   0, 95, 0,  1};
        tbl[3]  = '{96,   0,   0,   0, 0,  1,  1};
        tbl[4]  = '{200,  90,  60,  1, 81, 62, 1};
        tbl[5]  = '{200,  127, 60,  1, 86, 62, 1};
        tbl[6]  = '{200,  0,   63,  0, 8,  1,  1};
        tbl[7]  = '{200,  0,   100, 0, 8,  1,  1};
        tbl[8]  = '{6143, 0,   0,   0, 95, 63, 1};
        tbl[9]  = '{0,    0,   0,   0, 0,  0,  1};
        tbl[10] = '{7000, 0,   0,   0, 0,  0,  0};
        tbl[11] = '{5000, 1,   1,   0, 9,  53, 1};
        tbl[12] = '{6143, 0,   0,   1, 0,  63, 1};

        model_reset();
        #12;
        check("reset_x", int'(x), 0);
        check("reset_y", int'(y), 0);
        check("reset_cv", int'(cv), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        // table-driven vectors: apply, let any resync finish, then one edge to the output
        for (int i = 0; i < 13; i++) begin
            pi = tbl[i].pi[IW-1:0];
            ox = tbl[i].ox[CW-1:0];
            oy = tbl[i].oy[CW-1:0];
            mx = tbl[i].m[0];
            step();
            drain_busy("tbl");
            step();
            check($sformatf("tbl%0d_x", i), int'(x), tbl[i].ex);
            check($sformatf("tbl%0d_y", i), int'(y), tbl[i].ey);
            check($sformatf("tbl%0d_cv", i), int'(cv), tbl[i].ecv);
        end

        // stepping from reset, including the row wrap at 95 -> 96
        do_reset();
        ox = '0; oy = '0; mx = 1'b0;
        pi = '0;
        step();
        step();
        check("seq_cv_second_edge", int'(cv), 1);
        for (int k = 1; k <= 97; k++) begin
            pi = IW'(k);
            step();
            if (k == 96) begin
                check("row_wrap_last_x", int'(x), 95);
                check("row_wrap_last_y", int'(y), 0);
            end
            if (k == 97) begin
                check("row_wrap_first_x", int'(x), 0);
                check("row_wrap_first_y", int'(y), 1);
            end
        end

        // full frame then frame wrap back to 0
        pi = '0;
        step();
        saw_busy = 0;
        cv_drop = 0;
        for (int k = 1; k <= LAST; k++) begin
            pi = IW'(k);
            step();
            if (busy) saw_busy = 1;
            if (!cv) cv_drop = 1;
        end
        pi = '0;
        step();
        check("frame_last_x", int'(x), 95);
        check("frame_last_y", int'(y), 63);
        if (busy) saw_busy = 1;
        step();
        check("frame_wrap_x", int'(x), 0);
        check("frame_wrap_y", int'(y), 0);
        check("frame_wrap_cv", int'(cv), 1);
        check("frame_busy_seen", saw_busy, 0);
        check("frame_cv_drop", cv_drop, 0);

        // jump 10 -> 5000: 53 busy cycles
        pi = IW'(10);
        step();
        drain_busy("pre_jump");
        step();
        pi = IW'(5000);
        step();
        cnt = 0;
        cv_bad = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
            if (busy && cv) cv_bad = 1;
        end
        check("jump_busy_cycles", cnt, 53);
        check("jump_cv_low", cv_bad, 0);
        step();
        check("jump_x", int'(x), 8);
        check("jump_y", int'(y), 52);
        check("jump_cv", int'(cv), 1);

        // reset in the middle of a resync
        pi = IW'(6000);
        step();
        for (int k = 0; k < 5; k++) step();
        check("mid_resync_busy", int'(busy), 1);
        do_reset();
        pi = '0;
        step();
        step();
        check("post_rst_x", int'(x), 0);
        check("post_rst_y", int'(y), 0);
        check("post_rst_cv", int'(cv), 1);

        // randomized traffic against the model
        prev = 0;
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      prev = (prev >= LAST) ? 0 : prev + 1;
            else if (r < 70) prev = prev;
            else if (r < 80) prev = int'($urandom_range(0, LAST));
            else if (r < 85) prev = int'($urandom_range(LAST + 1, (1 << IW) - 1));
            else if (r < 90) prev = 0;
            else begin
                ox = CW'($urandom_range(0, (1 << CW) - 1));
                oy = CW'($urandom_range(0, (1 << CW) - 1));
                mx = 1'($urandom_range(0, 1));
            end
            pi = IW'(prev);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
